// File: rtl/fir_coeff_pkg.sv
// Shared command-word layout, opcodes, FSM states and status layout for the coefficient loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_coeff_pkg;

    localparam int TOGGLE_BIT = 31;
    localparam int OP_MSB     = 30;
    localparam int ADDR_LSB   = 18;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_NOP    = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EXEC,
        ST_SWAP_WAIT
    } state_t;

    localparam int STAT_BANK_BIT      = 31;
    localparam int STAT_PEND_BIT      = 30;
    localparam int STAT_ERR_RANGE_BIT = 29;
    localparam int STAT_ERR_OVR_BIT   = 28;

    typedef struct packed {
        logic        bank_sel;
        logic        swap_pending;
        logic        err_range;
        logic        err_overrun;
        logic [11:0] rsvd;
        logic [15:0] wr_count;
    } status_t;

endpackage

// File: rtl/fir_coeff_cmd_decode.sv
// Toggle edge detect on the host command word, then capture after a settle cycle.
// Latency: cmd_valid is high two cycles after the toggle edge is first sampled.
// Backpressure: none; the FSM consumes toggles and requests captures itself.
module fir_coeff_cmd_decode
    import fir_coeff_pkg::*;
#(
    parameter int COEFF_W = 18,
    parameter int ADDR_W  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        cmd_word,
    input  logic               consume,
    input  logic               capture,
    output logic               new_cmd,
    output logic               cmd_valid,
    output logic [1:0]         cmd_op,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic [COEFF_W-1:0] cmd_data
);

    logic last_toggle;

    assign new_cmd = cmd_word[TOGGLE_BIT] != last_toggle;

    // Tracking the live toggle during reset keeps a stale word from firing on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_toggle <= cmd_word[TOGGLE_BIT];
            cmd_valid   <= 1'b0;
            cmd_op      <= OP_NOP;
            cmd_addr    <= '0;
            cmd_data    <= '0;
        end else begin
            if (consume) begin
                last_toggle <= cmd_word[TOGGLE_BIT];
            end
            cmd_valid <= capture;
            if (capture) begin
                cmd_op   <= cmd_word[OP_MSB -: 2];
                cmd_addr <= cmd_word[ADDR_LSB +: ADDR_W];
                cmd_data <= cmd_word[COEFF_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// Executes host coefficient commands into the shadow bank and swaps banks at frame sync.
// Latency: coeff_we three cycles after the toggle edge is sampled; bank_sel one cycle after sync.
// Backpressure: none; commands arriving while a swap is pending are dropped and flagged.
module fir_coeff_load_ctrl
    import fir_coeff_pkg::*;
#(
    parameter int COEFF_W = 18,
    parameter int ADDR_W  = 11,
    parameter int NCOEFF  = 1024
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        cmd_word,
    input  logic               frame_sync,
    output logic               coeff_we,
    output logic [ADDR_W:0]    coeff_addr,
    output logic [COEFF_W-1:0] coeff_data,
    output logic               bank_sel,
    output logic [31:0]        status
);

    state_t state_q, state_d;

    logic               new_cmd, cmd_valid;
    logic [1:0]         cmd_op;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [COEFF_W-1:0] cmd_data;
    logic               addr_ok;

    logic consume, capture;
    logic do_write, do_range_err, do_commit, do_clear, do_swap, do_overrun;

    logic        swap_pending_q, err_range_q, err_overrun_q;
    logic [15:0] wr_count_q;
    status_t     status_q;

    fir_coeff_cmd_decode #(
        .COEFF_W(COEFF_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .cmd_word (cmd_word),
        .consume  (consume),
        .capture  (capture),
        .new_cmd  (new_cmd),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data)
    );

    assign addr_ok = {1'b0, cmd_addr} < (ADDR_W+1)'(NCOEFF);

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (new_cmd) state_d = ST_SETTLE;
            ST_SETTLE:    state_d = ST_EXEC;
            ST_EXEC:      state_d = (cmd_valid && cmd_op == OP_COMMIT) ? ST_SWAP_WAIT : ST_IDLE;
            ST_SWAP_WAIT: if (frame_sync) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // A toggle seen while waiting to swap is swallowed so the outgoing shadow bank stays frozen.
    always_comb begin
        consume      = new_cmd && (state_q == ST_IDLE || state_q == ST_SWAP_WAIT);
        capture      = state_q == ST_SETTLE;
        do_write     = state_q == ST_EXEC && cmd_valid && cmd_op == OP_WRITE && addr_ok;
        do_range_err = state_q == ST_EXEC && cmd_valid && cmd_op == OP_WRITE && !addr_ok;
        do_commit    = state_q == ST_EXEC && cmd_valid && cmd_op == OP_COMMIT;
        do_clear     = state_q == ST_EXEC && cmd_valid && cmd_op == OP_CLEAR;
        do_swap      = state_q == ST_SWAP_WAIT && frame_sync;
        do_overrun   = state_q == ST_SWAP_WAIT && new_cmd;
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            coeff_we       <= 1'b0;
            coeff_addr     <= '0;
            coeff_data     <= '0;
            bank_sel       <= 1'b0;
            swap_pending_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_overrun_q  <= 1'b0;
            wr_count_q     <= '0;
            status_q       <= '0;
        end else begin
            coeff_we <= do_write;
            if (do_write) begin
                coeff_addr <= {~bank_sel, cmd_addr};
                coeff_data <= cmd_data;
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (do_range_err) err_range_q   <= 1'b1;
            if (do_overrun)   err_overrun_q <= 1'b1;
            if (do_clear) begin
                err_range_q   <= 1'b0;
                err_overrun_q <= 1'b0;
                wr_count_q    <= '0;
            end
            if (do_commit) swap_pending_q <= 1'b1;
            if (do_swap) begin
                bank_sel       <= ~bank_sel;
                swap_pending_q <= 1'b0;
            end
            status_q <= {bank_sel, swap_pending_q, err_range_q, err_overrun_q, 12'b0, wr_count_q};
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Directed bench for the coefficient loader: a write scoreboard checked by a monitor plus status checks.
module tb_fir_coeff_load_ctrl;
    import fir_coeff_pkg::*;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] cmd_word;
    logic        frame_sync;
    logic        coeff_we;
    logic [11:0] coeff_addr;
    logic [17:0] coeff_data;
    logic        bank_sel;
    logic [31:0] status;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [17:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic tgl;

    fir_coeff_load_ctrl #(
        .COEFF_W(18),
        .ADDR_W (11),
        .NCOEFF (1024)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .cmd_word  (cmd_word),
        .frame_sync(frame_sync),
        .coeff_we  (coeff_we),
        .coeff_addr(coeff_addr),
        .coeff_data(coeff_data),
        .bank_sel  (bank_sel),
        .status    (status)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge user_clk);
    endtask

    // Called on a negedge; the toggle is first sampled at the next posedge.
    task automatic send(input logic [1:0] op, input logic [10:0] addr, input logic [17:0] data,
                        input bit exp_wr, input bit exp_bank);
        exp_t e;
        tgl = ~tgl;
        cmd_word = {tgl, op, addr, data};
        if (exp_wr) begin
            e.cyc  = cyc + 3;
            e.addr = {exp_bank, addr};
            e.data = data;
            sb.push_back(e);
        end
    endtask

    always @(negedge user_clk) begin
        if (coeff_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h at cycle %0d, none expected",
                         coeff_addr, coeff_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                check("wr_addr", {20'b0, coeff_addr}, {20'b0, e.addr});
                check("wr_data", {14'b0, coeff_data}, {14'b0, e.data});
            end
        end
    end

    initial begin
        user_rst_n = 1'b0;
        cmd_word   = 32'h8000_0000;
        frame_sync = 1'b0;
        tgl        = 1'b1;

        // Reset with a stale toggle already set
        tick(4);
        check("rst_we", {31'b0, coeff_we}, 32'h0);
        check("rst_addr", {20'b0, coeff_addr}, 32'h0);
        check("rst_data", {14'b0, coeff_data}, 32'h0);
        user_rst_n = 1'b1;
        tick(5);
        check("idle_bank", {31'b0, bank_sel}, 32'h0);
        check("idle_status", status, 32'h0);

        // Basic write into shadow bank 1
        send(OP_WRITE, 11'h005, 18'h1ABCD, 1, 1);
        tick(6);
        check("write_status", status, 32'h0000_0001);

        // Range error at NCOEFF, then clear, then the last legal address
        send(OP_WRITE, 11'h400, 18'h00055, 0, 0);
        tick(6);
        check("range_status", status, 32'h2000_0001);
        check("range_bit", {31'b0, status[STAT_ERR_RANGE_BIT]}, 32'h1);
        send(OP_CLEAR, 11'h000, 18'h0, 0, 0);
        tick(6);
        check("clear_status", status, 32'h0);
        send(OP_WRITE, 11'h3FF, 18'h00001, 1, 1);
        tick(6);
        check("lastaddr_status", status, 32'h0000_0001);

        // Commit, sync ten cycles later
        send(OP_COMMIT, 11'h000, 18'h0, 0, 0);
        tick(10);
        check("pend_status", status, 32'h4000_0001);
        check("pend_bank", {31'b0, bank_sel}, 32'h0);
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        check("swap_bank", {31'b0, bank_sel}, 32'h1);
        tick(1);
        check("swap_status", status, 32'h8000_0001);
        check("swap_bank_bit", {31'b0, status[STAT_BANK_BIT]}, 32'h1);

        // Sync outside SWAP_WAIT has no effect
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        tick(2);
        check("idle_sync_bank", {31'b0, bank_sel}, 32'h1);
        send(OP_WRITE, 11'h010, 18'h20000, 1, 0);
        tick(6);
        check("bank0_write_status", status, 32'h8000_0002);

        // Overrun: write during SWAP_WAIT is dropped
        send(OP_COMMIT, 11'h000, 18'h0, 0, 0);
        tick(6);
        send(OP_WRITE, 11'h020, 18'h00777, 0, 0);
        tick(6);
        check("ovr_status", status, 32'hD000_0002);
        check("ovr_bit", {31'b0, status[STAT_ERR_OVR_BIT]}, 32'h1);
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        tick(2);
        check("ovr_swap_status", status, 32'h1000_0002);
        check("ovr_swap_bank", {31'b0, bank_sel}, 32'h0);
        send(OP_CLEAR, 11'h000, 18'h0, 0, 0);
        tick(6);
        check("ovr_clear_status", status, 32'h0);

        // Toggle and frame_sync in the same cycle
        send(OP_COMMIT, 11'h000, 18'h0, 0, 0);
        tick(6);
        check("same_pend_status", status, 32'h4000_0000);
        frame_sync = 1'b1;
        send(OP_WRITE, 11'h030, 18'h00999, 0, 0);
        tick(1);
        frame_sync = 1'b0;
        check("same_bank", {31'b0, bank_sel}, 32'h1);
        tick(6);
        check("same_status", status, 32'h9000_0000);
        send(OP_CLEAR, 11'h000, 18'h0, 0, 0);
        tick(6);
        check("same_clear_status", status, 32'h8000_0000);

        // Reset while a swap is pending, with a stale toggle during reset
        send(OP_COMMIT, 11'h000, 18'h0, 0, 0);
        tick(6);
        check("mid_pend_status", status, 32'hC000_0000);
        check("mid_pend_bit", {31'b0, status[STAT_PEND_BIT]}, 32'h1);
        user_rst_n = 1'b0;
        send(OP_WRITE, 11'h002, 18'h00ABC, 0, 0);
        tick(3);
        check("mid_rst_bank", {31'b0, bank_sel}, 32'h0);
        user_rst_n = 1'b1;
        tick(8);
        check("mid_after_status", status, 32'h0);
        check("mid_after_bank", {31'b0, bank_sel}, 32'h0);
        send(OP_WRITE, 11'h001, 18'h3FFFF, 1, 1);
        tick(6);
        check("post_rst_status", status, 32'h0000_0001);

        tick(4);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
